watch_cnt: RTL and testbench

WATCH_CNT -- requirements
Module: watch_cnt

---
 rtl/watch_cnt.sv | 147 ++++++++++++++
 tb/tb_watch_cnt.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/watch_cnt.sv
// -----------------------------------------------------------------------------
// watch_cnt -- stopwatch time base and MM:SS.t BCD counter.
//
// A prescaler divides CLK by TICK_DIV to make a 0.1 s tick. Each tick advances
// a five-digit BCD count (M M : S S . t) that wraps 59:59.9 -> 00:00.0 and
// pulses ROLLOVER for that one cycle. The digits move on the tick edge itself.
//
// Optional feature (macro WATCH_LAP_EN): a set of display registers that follow
// the live count while LAP=0 and freeze while LAP=1. The live count keeps
// running underneath. Without the macro the outputs are the live count
// registers and LAP is ignored.
//
// Parameters
//   TICK_DIV  CLK cycles per 0.1 s tick, 2..2^20
// Ports
//   CLK       sole clock, rising edge
//   RESET_N   asynchronous active-low reset
//   CLKEN     count enable (synchronous, registered upstream)
//   RST       synchronous clear, overrides CLKEN and LAP
//   LAP       display hold request (used only with WATCH_LAP_EN)
//   TENTHS, SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS   BCD digits, registered
//   ROLLOVER  one-cycle pulse on the 59:59.9 -> 00:00.0 wrap, registered
// -----------------------------------------------------------------------------
module watch_cnt #(
  parameter int TICK_DIV = 100000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CLKEN,
  input  logic       RST,
  input  logic       LAP,
  output logic [3:0] TENTHS,
  output logic [3:0] SEC_ONES,
  output logic [2:0] SEC_TENS,
  output logic [3:0] MIN_ONES,
  output logic [2:0] MIN_TENS,
  output logic       ROLLOVER
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef struct packed {
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } time_t;

  // Last count before the wrap: 59:59.9.
  localparam time_t WRAP_VAL = '{min_tens: 3'd5, min_ones: 4'd9,
                                 sec_tens: 3'd5, sec_ones: 4'd9, tenths: 4'd9};

  logic [PW-1:0] presc, presc_d;
  time_t         cnt, cnt_d;
  logic          roll, roll_d;
  time_t         shown;

  // Next-state logic. The digits use next values directly so that they
  // change on the tick edge with no extra pipeline stage.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    presc_d = presc;
    cnt_d   = cnt;
    roll_d  = 1'b0;
    if (RST) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (CLKEN) begin
      if (presc != PRESC_LAST) begin
        presc_d = presc + 1'b1;
      end else begin
        presc_d = '0;
        roll_d  = (cnt == WRAP_VAL);
        // Ripple carry through the digits; each stage only moves when all
        // lower stages are at their maximum.
        if (cnt.tenths != 4'd9) begin
          cnt_d.tenths = cnt.tenths + 4'd1;
        end else begin
          cnt_d.tenths = '0;
          if (cnt.sec_ones != 4'd9) begin
            cnt_d.sec_ones = cnt.sec_ones + 4'd1;
          end else begin
            cnt_d.sec_ones = '0;
            if (cnt.sec_tens != 3'd5) begin
              cnt_d.sec_tens = cnt.sec_tens + 3'd1;
            end else begin
              cnt_d.sec_tens = '0;
              if (cnt.min_ones != 4'd9) begin
                cnt_d.min_ones = cnt.min_ones + 4'd1;
              end else begin
                cnt_d.min_ones = '0;
                cnt_d.min_tens = (cnt.min_tens == 3'd5) ? 3'd0
                                                        : cnt.min_tens + 3'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc <= '0;
      cnt   <= '0;
      roll  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples values from before the edge, independent of statement order.
      presc <= presc_d;
      cnt   <= cnt_d;
      roll  <= roll_d;
    end
  end

`ifdef WATCH_LAP_EN
  // Display copy of the count. It loads the same next value as the live
  // registers, so with LAP=0 it is identical to the live count. RST clears it
  // even while LAP is held.
  time_t disp;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      disp <= '0;
    end else if (RST || !LAP) begin
      disp <= cnt_d;
    end
  end

  assign shown = disp;
`else
  logic unused_lap;
  assign unused_lap = LAP;
  assign shown      = cnt;
`endif

  assign TENTHS   = shown.tenths;
  assign SEC_ONES = shown.sec_ones;
  assign SEC_TENS = shown.sec_tens;
  assign MIN_ONES = shown.min_ones;
  assign MIN_TENS = shown.min_tens;
  assign ROLLOVER = roll;

endmodule

// File: tb/tb_watch_cnt.sv
// -----------------------------------------------------------------------------
// tb_watch_cnt -- scoreboard bench for watch_cnt.
//
// u_dut  (TICK_DIV=4): reset, counting, pause, RST priority, lap, async reset.
// u_wrap (TICK_DIV=2): free-runs from reset to the 59:59.9 -> 00:00.0 wrap,
//                      in parallel with the u_dut sequence.
// Stimulus pushes {cycle, name, expected outputs} into a per-instance queue;
// a monitor on the falling clock edge pops entries whose cycle has arrived
// and compares them against the outputs. Expected values are packed one
// nibble per field: {rollover, min_tens, min_ones, sec_tens, sec_ones, tenths}.
// -----------------------------------------------------------------------------
module tb_watch_cnt;

  logic       CLK;
  logic       RESET_N, CLKEN, RST, LAP;
  logic [3:0] TENTHS, SEC_ONES, MIN_ONES;
  logic [2:0] SEC_TENS, MIN_TENS;
  logic       ROLLOVER;

  logic       wrap_rst_n, wrap_clken;
  logic [3:0] w_tenths, w_sec_ones, w_min_ones;
  logic [2:0] w_sec_tens, w_min_tens;
  logic       w_rollover;

  watch_cnt #(.TICK_DIV(4)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLKEN(CLKEN), .RST(RST), .LAP(LAP),
    .TENTHS(TENTHS), .SEC_ONES(SEC_ONES), .SEC_TENS(SEC_TENS),
    .MIN_ONES(MIN_ONES), .MIN_TENS(MIN_TENS), .ROLLOVER(ROLLOVER)
  );

  watch_cnt #(.TICK_DIV(2)) u_wrap (
    .CLK(CLK), .RESET_N(wrap_rst_n), .CLKEN(wrap_clken), .RST(1'b0), .LAP(1'b0),
    .TENTHS(w_tenths), .SEC_ONES(w_sec_ones), .SEC_TENS(w_sec_tens),
    .MIN_ONES(w_min_ones), .MIN_TENS(w_min_tens), .ROLLOVER(w_rollover)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    int          at_cyc;
    string       name;
    logic [23:0] val;
  } exp_t;

  exp_t sb_main[$];
  exp_t sb_wrap[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [23:0] act,
                       input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %06h expected %06h (r,MM,SS,t)", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pack(input logic r, input logic [2:0] mt,
                                       input logic [3:0] mo, input logic [2:0] st,
                                       input logic [3:0] so, input logic [3:0] t);
    return {3'b0, r, 1'b0, mt, mo, 1'b0, st, so, t};
  endfunction

  // Expectation for u_dut at the falling edge of the current cycle.
  task automatic exp_main(input string name, input int mt, input int mo,
                          input int st, input int so, input int t, input int r);
    exp_t e;
    e.at_cyc = cyc;
    e.name   = name;
    e.val    = pack(r[0], mt[2:0], mo[3:0], st[2:0], so[3:0], t[3:0]);
    sb_main.push_back(e);
  endtask

  task automatic exp_wrap(input string name, input int at, input int mt,
                          input int mo, input int st, input int so,
                          input int t, input int r);
    exp_t e;
    e.at_cyc = at;
    e.name   = name;
    e.val    = pack(r[0], mt[2:0], mo[3:0], st[2:0], so[3:0], t[3:0]);
    sb_wrap.push_back(e);
  endtask

  // Monitor: falling edge, away from the rising edge that updates the DUT.
  always @(negedge CLK) begin
    exp_t e;
    while (sb_main.size() > 0 && sb_main[0].at_cyc <= cyc) begin
      e = sb_main.pop_front();
      check(e.name, pack(ROLLOVER, MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES, TENTHS),
            e.val);
    end
    while (sb_wrap.size() > 0 && sb_wrap[0].at_cyc <= cyc) begin
      e = sb_wrap.pop_front();
      check(e.name, pack(w_rollover, w_min_tens, w_min_ones, w_sec_tens,
                         w_sec_ones, w_tenths), e.val);
    end
  end

  // Advance n rising edges; inputs change 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int c0;
    RESET_N    = 1'b0;
    CLKEN      = 1'b0;
    RST        = 1'b0;
    LAP        = 1'b0;
    wrap_rst_n = 1'b0;
    wrap_clken = 1'b0;

    step(2);
    exp_main("reset_state", 0, 0, 0, 0, 0, 0);

    // Release both instances; u_wrap free-runs from here.
    RESET_N    = 1'b1;
    wrap_rst_n = 1'b1;
    wrap_clken = 1'b1;
    c0 = cyc;
    exp_wrap("wrap_reset_state", c0,         0, 0, 0, 0, 0, 0);
    exp_wrap("wrap_preload",     c0 + 71998, 5, 9, 5, 9, 9, 0);
    exp_wrap("wrap_hold_partial",c0 + 71999, 5, 9, 5, 9, 9, 0);
    exp_wrap("wrap_to_zero",     c0 + 72000, 0, 0, 0, 0, 0, 1);
    exp_wrap("wrap_pulse_end",   c0 + 72001, 0, 0, 0, 0, 0, 0);
    exp_wrap("wrap_next_tick",   c0 + 72002, 0, 0, 0, 0, 1, 0);

    // Counting from clear: ticks every 4 enabled edges.
    CLKEN = 1'b1;
    step(3);  exp_main("count_pre_tick",   0, 0, 0, 0, 0, 0);
    step(1);  exp_main("count_first_tick", 0, 0, 0, 0, 1, 0);
    step(35); exp_main("count_edge39",     0, 0, 0, 0, 9, 0);
    step(1);  exp_main("count_edge40",     0, 0, 0, 1, 0, 0);

    // Synchronous clear.
    CLKEN = 1'b0;
    RST   = 1'b1;
    step(1);  exp_main("rst_clear", 0, 0, 0, 0, 0, 0);
    RST = 1'b0;

    // Pause keeps the partial tick.
    CLKEN = 1'b1;
    step(6);  exp_main("pause_before", 0, 0, 0, 0, 1, 0);
    CLKEN = 1'b0;
    step(20); exp_main("pause_hold",   0, 0, 0, 0, 1, 0);
    CLKEN = 1'b1;
    step(1);  exp_main("resume_edge1", 0, 0, 0, 0, 1, 0);
    step(1);  exp_main("resume_edge2", 0, 0, 0, 0, 2, 0);

    // RST beats CLKEN (and LAP) at 00:03.4 with prescaler at 2.
    step(130); exp_main("rst_pri_before", 0, 0, 0, 3, 4, 0);
    RST = 1'b1;
    LAP = 1'b1;
    step(1);   exp_main("rst_priority",   0, 0, 0, 0, 0, 0);
    RST = 1'b0;
    LAP = 1'b0;
    step(3);   exp_main("rst_no_early_tick", 0, 0, 0, 0, 0, 0);
    step(1);   exp_main("rst_first_tick",    0, 0, 0, 0, 1, 0);

    // Lap hold at 00:01.0; live count keeps running underneath.
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    step(40);  exp_main("lap_start", 0, 0, 0, 1, 0, 0);
    LAP = 1'b1;
`ifdef WATCH_LAP_EN
    step(10);  exp_main("lap_hold_mid", 0, 0, 0, 1, 0, 0);
    step(10);  exp_main("lap_hold_end", 0, 0, 0, 1, 0, 0);
`else
    step(10);  exp_main("lap_ignored_mid", 0, 0, 0, 1, 2, 0);
    step(10);  exp_main("lap_ignored_end", 0, 0, 0, 1, 5, 0);
`endif
    LAP = 1'b0;
    step(1);   exp_main("lap_release", 0, 0, 0, 1, 5, 0);
    LAP = 1'b1;
    step(3);
    RST = 1'b1;
    step(1);   exp_main("rst_during_lap", 0, 0, 0, 0, 0, 0);
    RST = 1'b0;
    LAP = 1'b0;

    // Asynchronous reset at 00:12.3 with a partial tick in the prescaler.
    step(494); exp_main("pre_async_reset", 0, 0, 1, 2, 3, 0);
    CLKEN = 1'b0;
    step(1);
    RESET_N = 1'b0;
    exp_main("async_reset", 0, 0, 0, 0, 0, 0);
    step(2);
    RESET_N = 1'b1;
    CLKEN   = 1'b1;
    step(3);   exp_main("reset_partial_discard", 0, 0, 0, 0, 0, 0);
    step(1);   exp_main("post_reset_first_tick", 0, 0, 0, 0, 1, 0);

    // Let the monitor drain both queues, within a bounded number of cycles.
    step(2);
    for (int i = 0; i < 80000 && sb_wrap.size() > 0; i++) @(posedge CLK);
    step(2);
    check("main_queue_drained", 24'(sb_main.size()), 24'd0);
    check("wrap_queue_drained", 24'(sb_wrap.size()), 24'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
